// File: rtl/uart_receiver_if.sv
// Read port of the UART receive FIFO: head byte, status flags and pop strobe.
// The register block is the master; the receiver is the slave.
interface uart_receiver_if;
   logic       re;
   logic [7:0] dout;
   logic       rx_queue_empty;
   logic       rx_queue_full;

   modport master (output re, input dout, rx_queue_empty, rx_queue_full);
   modport slave  (input re, output dout, rx_queue_empty, rx_queue_full);
endinterface

// File: rtl/uart_receiver.sv
// UART receive half: 16x oversampled frame decoder (5-8 data bits, optional parity,
// 1 or 2 stop bits) feeding a first-word-fall-through byte FIFO.
module uart_receiver #(
   parameter int RX_QUEUE_SIZE = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           rx,
   input  logic           sample_en,
   input  logic [1:0]     data_bits_count,
   input  logic [1:0]     parity_type,
   input  logic           double_stop_bits,
   uart_receiver_if.slave rxq,
   output logic           parity_error,
   output logic           stop_bit_error,
   output logic           overrun_error,
   output logic           busy
);
   localparam int AW = $clog2(RX_QUEUE_SIZE);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t        state, state_nxt;
   logic          sync1, rx_s;
   logic [3:0]    tcnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic [1:0]    n_cfg, par_cfg;
   logic          stop2_cfg;
   logic          s7, s8, bit_q, vote_now;
   logic          par_bad, stop_bad;
   logic          start_det, shift_en, par_chk, stop_val, frame_done, frame_stop_bad;
   logic [7:0]    mem [RX_QUEUE_SIZE];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          q_empty, q_full, push, pop;

   // NOTE: every state element uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx;
         rx_s  <= sync1;
      end
   end

   assign vote_now = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
   always_comb begin
      state_nxt  = state;
      start_det  = 1'b0;
      shift_en   = 1'b0;
      par_chk    = 1'b0;
      stop_val   = 1'b1;
      frame_done = 1'b0;
      if (sample_en) begin
         case (state)
            IDLE:   if (!rx_s) begin
                       state_nxt = START;
                       start_det = 1'b1;
                    end
            START:  if (tcnt == 4'd9 && vote_now) state_nxt = IDLE;
                    else if (tcnt == 4'd15)       state_nxt = DATA;
            DATA:   if (tcnt == 4'd15) begin
                       shift_en = 1'b1;
                       if (bit_idx == {1'b0, n_cfg} + 3'd4)
                          state_nxt = (par_cfg != 2'b00) ? PARITY : STOP1;
                    end
            PARITY: if (tcnt == 4'd15) begin
                       par_chk   = 1'b1;
                       state_nxt = STOP1;
                    end
            STOP1:  if (stop2_cfg) begin
                       if (tcnt == 4'd15) begin
                          stop_val  = bit_q;
                          state_nxt = STOP2;
                       end
                    end else if (tcnt == 4'd9) begin
                       stop_val   = vote_now;
                       frame_done = 1'b1;
                       state_nxt  = IDLE;
                    end
            STOP2:  if (tcnt == 4'd9) begin
                       stop_val   = vote_now;
                       frame_done = 1'b1;
                       state_nxt  = IDLE;
                    end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign frame_stop_bad = stop_bad | ~stop_val;

   // Frame datapath: tick counter, vote samples, shift register and error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt      <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         n_cfg     <= '0;
         par_cfg   <= '0;
         stop2_cfg <= 1'b0;
         s7        <= 1'b1;
         s8        <= 1'b1;
         bit_q     <= 1'b1;
         par_bad   <= 1'b0;
         stop_bad  <= 1'b0;
      end else if (sample_en) begin
         tcnt <= (state == IDLE || state_nxt == IDLE) ? 4'd0 : tcnt + 4'd1;
         if (tcnt == 4'd7) s7 <= rx_s;
         if (tcnt == 4'd8) s8 <= rx_s;
         if (tcnt == 4'd9) bit_q <= vote_now;
         if (start_det) begin
            n_cfg     <= data_bits_count;
            par_cfg   <= parity_type;
            stop2_cfg <= double_stop_bits;
            shift_reg <= '0;
            bit_idx   <= '0;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
         end
         if (shift_en) begin
            shift_reg[bit_idx] <= bit_q;
            bit_idx            <= bit_idx + 3'd1;
         end
         if (par_chk) par_bad <= ((^shift_reg) ^ bit_q) != par_cfg[1];
         if (!stop_val) stop_bad <= 1'b1;
      end
   end

   assign q_empty = (count == '0);
   assign q_full  = (count == CW'(RX_QUEUE_SIZE));
   assign pop     = rxq.re && !q_empty;
   assign push    = frame_done && !frame_stop_bad && (!q_full || rxq.re);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         parity_error   <= 1'b0;
         stop_bit_error <= 1'b0;
         overrun_error  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count          <= count + CW'(push) - CW'(pop);
         parity_error   <= frame_done && par_bad;
         stop_bit_error <= frame_done && frame_stop_bad;
         overrun_error  <= frame_done && !frame_stop_bad && q_full && !rxq.re;
      end
   end

   // NOTE: storage is not reset; count marks which entries are valid, so clearing pointers suffices.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shift_reg;
   end

   assign rxq.dout           = q_empty ? 8'h00 : mem[rd_ptr];
   assign rxq.rx_queue_empty = q_empty;
   assign rxq.rx_queue_full  = q_full;
   assign busy               = (state != IDLE);
endmodule
